// File: rtl/ioctl_stream_tx_if.sv
// ioctl download bus: the signals a transmitter drives into a core.
// master = bus driver (ioctl_stream_tx), slave = consuming core.
interface ioctl_stream_tx_if #(
  parameter int AW = 25
) ();
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout
  );
endinterface

// File: rtl/ioctl_stream_tx.sv
// ioctl_stream_tx: replays a byte image from a 1-cycle-latency source memory
// as an ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout stream.
// Optional feature macro: IOCTL_TX_CHECKSUM_EN adds checksum[7:0], the
// mod-256 sum of every byte written in the current/last transfer.
module ioctl_stream_tx #(
  parameter int AW        = 25,
  parameter int LEN_W     = 16,
  parameter int GAP       = 3,
  parameter int SETUP_CYC = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       index,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             src_rd,
  output logic [LEN_W-1:0] src_addr,
  input  logic [7:0]       src_data,
`ifdef IOCTL_TX_CHECKSUM_EN
  output logic [7:0]       checksum,
`endif
  ioctl_stream_tx_if.master ioctl
);

  localparam int CMAX = (GAP > SETUP_CYC) ? GAP : SETUP_CYC;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_READ, S_WAIT, S_WRITE, S_GAP, S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [LEN_W-1:0] r_n;
  logic [LEN_W-1:0] r_len;
  logic [AW-1:0]    r_base;
  logic [AW-1:0]    r_addr;
  logic [7:0]       r_index;
  logic [7:0]       r_dout;
  logic             r_aborted;
  logic             w_busy;
  logic             w_last;
`ifdef IOCTL_TX_CHECKSUM_EN
  logic [7:0]       r_checksum;
`endif

  assign w_last = (r_n == r_len - 1'b1);

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and Moore outputs; abort overrides every busy state
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    done        = 1'b0;
    src_rd      = 1'b0;
    ioctl.ioctl_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (length == '0) ? S_FINISH : S_SETUP;
      end
      S_SETUP: begin
        w_busy = 1'b1;
        if (abort)                            w_state_nxt = S_FINISH;
        else if (r_cnt == CW'(SETUP_CYC - 1)) w_state_nxt = S_READ;
      end
      S_READ: begin
        w_busy = 1'b1;
        src_rd = 1'b1;
        w_state_nxt = abort ? S_FINISH : S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        w_state_nxt = abort ? S_FINISH : S_WRITE;
      end
      S_WRITE: begin
        w_busy = 1'b1;
        ioctl.ioctl_wr = 1'b1;
        if (abort)         w_state_nxt = S_FINISH;
        else if (GAP != 0) w_state_nxt = S_GAP;
        else               w_state_nxt = w_last ? S_FINISH : S_READ;
      end
      S_GAP: begin
        w_busy = 1'b1;
        if (abort)                      w_state_nxt = S_FINISH;
        else if (r_cnt == CW'(GAP - 1)) w_state_nxt = w_last ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request latch, byte counter, capture of read data and address
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt     <= '0;
      r_n       <= '0;
      r_len     <= '0;
      r_base    <= '0;
      r_addr    <= '0;
      r_index   <= '0;
      r_dout    <= '0;
      r_aborted <= 1'b0;
`ifdef IOCTL_TX_CHECKSUM_EN
      r_checksum <= '0;
`endif
    end else begin
      if ((w_state_nxt == r_state) && (r_state == S_SETUP || r_state == S_GAP))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      if (r_state == S_IDLE && start) begin
        r_index   <= index;
        r_base    <= base_addr;
        r_len     <= length;
        r_n       <= '0;
        r_aborted <= 1'b0;
`ifdef IOCTL_TX_CHECKSUM_EN
        r_checksum <= '0;
`endif
      end

      // Captured only on the way into WRITE, so a byte aborted in READ/WAIT
      // leaves the previous address/data on the bus.
      if (r_state == S_WAIT && w_state_nxt == S_WRITE) begin
        r_dout <= src_data;
        r_addr <= r_base + AW'(r_n);
      end

      if (w_state_nxt == S_READ && r_state != S_SETUP)
        r_n <= r_n + 1'b1;

      if (w_busy && abort)
        r_aborted <= 1'b1;

`ifdef IOCTL_TX_CHECKSUM_EN
      if (r_state == S_WRITE)
        r_checksum <= r_checksum + r_dout;
`endif
    end
  end

  assign busy                 = w_busy;
  assign aborted              = r_aborted;
  assign src_addr             = r_n;
  assign ioctl.ioctl_download = w_busy;
  assign ioctl.ioctl_index    = r_index;
  assign ioctl.ioctl_addr     = r_addr;
  assign ioctl.ioctl_dout     = r_dout;
`ifdef IOCTL_TX_CHECKSUM_EN
  assign checksum             = r_checksum;
`endif

endmodule
